// File: rtl/ponto_fixo_multi_seq.sv
// Sequential Qm.n fixed-point multiplier with one shift-add step per clock and valid/ready handshakes.
// Define PONTO_FIXO_ACC_EN to add a running accumulator of p_raw (acc_clr / acc_out ports).
module ponto_fixo_multi_seq #(
   parameter int N        = 8,
   parameter int NFRAC    = 3,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   p_raw,
   output logic [N-1:0]     p_qm_n,
   output logic             overflow,
   output logic             busy
`ifdef PONTO_FIXO_ACC_EN
   ,
   input  logic             acc_clr,
   output logic [2*N+3:0]   acc_out
`endif
);

   localparam int CW     = $clog2(N);
   localparam int PW     = 2*N + 2;
   localparam int RND_SH = (NFRAC > 0) ? NFRAC - 1 : 0;

   localparam logic [N-1:0]          ONE_N = 1;
   localparam logic [2*N:0]          ONE_P = 1;
   localparam logic signed [PW-1:0]  ONE_W = 1;
   localparam logic signed [PW-1:0]  RND   = (NFRAC > 0) ? (ONE_W <<< RND_SH) : '0;
   localparam logic signed [PW-1:0]  HI    = (SIGNED != 0) ? ((ONE_W <<< (N-1)) - ONE_W)
                                                           : ((ONE_W <<< N) - ONE_W);
   localparam logic signed [PW-1:0]  LO    = (SIGNED != 0) ? -(ONE_W <<< (N-1)) : '0;

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2*N-1:0]    mcand_q, mcand_d;
   logic [N-1:0]      mplier_q, mplier_d;
   logic [2*N-1:0]    acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic [2*N-1:0]    p_raw_q, p_raw_d;
   logic [N-1:0]      p_qm_n_q, p_qm_n_d;
   logic              overflow_q, overflow_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;

   logic [N-1:0]      mag_a, mag_b;
   logic [2*N:0]      acc_ext, prod;
   logic signed [PW-1:0] prod_x, r;
   logic              over_hi, over_lo;

   // Magnitudes keep the most negative operand representable as an unsigned N-bit value.
   always_comb begin
      mag_a = a;
      mag_b = b;
      if (SIGNED != 0 && a[N-1]) mag_a = ~a + ONE_N;
      if (SIGNED != 0 && b[N-1]) mag_b = ~b + ONE_N;
   end

   always_comb begin
      acc_ext = {1'b0, acc_q};
      prod    = sign_q ? (~acc_ext + ONE_P) : acc_ext;
      prod_x  = $signed({prod[2*N], prod});
      r       = (prod_x + RND) >>> NFRAC;
      over_hi = (r > HI);
      over_lo = (r < LO);
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      p_raw_d     = p_raw_q;
      p_qm_n_d    = p_qm_n_q;
      overflow_d  = overflow_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d    = {{N{1'b0}}, mag_a};
               mplier_d   = mag_b;
               sign_d     = (SIGNED != 0) ? (a[N-1] ^ b[N-1]) : 1'b0;
               acc_d      = '0;
               cnt_d      = '0;
               state_d    = S_CALC;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_CALC: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(N-1)) state_d = S_ROUND;
         end
         S_ROUND: begin
            p_raw_d    = prod[2*N-1:0];
            overflow_d = over_hi | over_lo;
            if ((over_hi | over_lo) && SATURATE != 0)
               p_qm_n_d = over_hi ? HI[N-1:0] : LO[N-1:0];
            else
               p_qm_n_d = r[N-1:0];
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         p_raw_q     <= '0;
         p_qm_n_q    <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         p_raw_q     <= p_raw_d;
         p_qm_n_q    <= p_qm_n_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign p_raw     = p_raw_q;
   assign p_qm_n    = p_qm_n_q;
   assign overflow  = overflow_q;
   assign busy      = busy_q;

`ifdef PONTO_FIXO_ACC_EN
   logic [2*N+3:0] acc_out_q, acc_out_d, p_ext;
   logic           out_hs;

   // Clear wins over accumulation, but a coincident result is loaded rather than lost.
   always_comb begin
      p_ext     = (SIGNED != 0) ? {{4{p_raw_q[2*N-1]}}, p_raw_q} : {4'b0000, p_raw_q};
      out_hs    = (state_q == S_DONE) && out_ready;
      acc_out_d = acc_out_q;
      if (acc_clr && out_hs)  acc_out_d = p_ext;
      else if (acc_clr)       acc_out_d = '0;
      else if (out_hs)        acc_out_d = acc_out_q + p_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_out_q <= '0;
      else        acc_out_q <= acc_out_d;
   end

   assign acc_out = acc_out_q;
`endif

endmodule

// File: tb/tb_ponto_fixo_multi_seq.sv
// Scoreboard bench for ponto_fixo_multi_seq: unsigned/saturating, unsigned/wrapping and signed instances.
module tb_ponto_fixo_multi_seq;
   localparam int N = 8;
   localparam int W = 2*N + N + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] a, b;
   logic out_ready;
   logic iv_u, iv_w, iv_s;
   logic ir_u, ir_w, ir_s;
   logic ov_u, ov_w, ov_s;
   logic [2*N-1:0] praw_u, praw_w, praw_s;
   logic [N-1:0] pq_u, pq_w, pq_s;
   logic ovf_u, ovf_w, ovf_s;
   logic busy_u, busy_w, busy_s;
`ifdef PONTO_FIXO_ACC_EN
   logic acc_clr = 1'b0;
   logic [2*N+3:0] acc_u, acc_w, acc_s;
`endif

   logic [W-1:0] exp_u[$];
   logic [W-1:0] exp_w[$];
   logic [W-1:0] exp_s[$];
   int n_checks = 0;
   int n_errors = 0;

   ponto_fixo_multi_seq #(.N(N), .NFRAC(3), .SIGNED(0), .SATURATE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u), .a(a), .b(b),
      .out_valid(ov_u), .out_ready(out_ready), .p_raw(praw_u), .p_qm_n(pq_u),
      .overflow(ovf_u), .busy(busy_u)
`ifdef PONTO_FIXO_ACC_EN
      , .acc_clr(acc_clr), .acc_out(acc_u)
`endif
   );

   ponto_fixo_multi_seq #(.N(N), .NFRAC(3), .SIGNED(0), .SATURATE(0)) w_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w), .a(a), .b(b),
      .out_valid(ov_w), .out_ready(out_ready), .p_raw(praw_w), .p_qm_n(pq_w),
      .overflow(ovf_w), .busy(busy_w)
`ifdef PONTO_FIXO_ACC_EN
      , .acc_clr(acc_clr), .acc_out(acc_w)
`endif
   );

   ponto_fixo_multi_seq #(.N(N), .NFRAC(3), .SIGNED(1), .SATURATE(1)) s_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .a(a), .b(b),
      .out_valid(ov_s), .out_ready(out_ready), .p_raw(praw_s), .p_qm_n(pq_s),
      .overflow(ovf_s), .busy(busy_s)
`ifdef PONTO_FIXO_ACC_EN
      , .acc_clr(acc_clr), .acc_out(acc_s)
`endif
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic chk_res(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
      chk({nm, "_p_raw"}, 32'(got[W-1:N+1]), 32'(want[W-1:N+1]));
      chk({nm, "_p_qm_n"}, 32'(got[N:1]), 32'(want[N:1]));
      chk({nm, "_overflow"}, 32'(got[0]), 32'(want[0]));
   endtask

   task automatic unexpected(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected_output: got out_valid=1, expected no result", nm);
   endtask

   // Monitor: a result transfers on the next rising edge when out_valid and out_ready are high.
   always @(negedge clk) begin
      if (rst_n && out_ready) begin
         if (ov_u) begin
            if (exp_u.size() == 0) unexpected("u");
            else chk_res("u", {praw_u, pq_u, ovf_u}, exp_u.pop_front());
         end
         if (ov_w) begin
            if (exp_w.size() == 0) unexpected("w");
            else chk_res("w", {praw_w, pq_w, ovf_w}, exp_w.pop_front());
         end
         if (ov_s) begin
            if (exp_s.size() == 0) unexpected("s");
            else chk_res("s", {praw_s, pq_s, ovf_s}, exp_s.pop_front());
         end
      end
   end

   function automatic logic rdy(input int which);
      case (which)
         0:       return ir_u;
         1:       return ir_w;
         default: return ir_s;
      endcase
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input int which, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [W-1:0] e, input bit push);
      int t;
      t = 0;
      while (!rdy(which) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, expected 1");
         return;
      end
      a = aa;
      b = bb;
      if (push) begin
         case (which)
            0:       exp_u.push_back(e);
            1:       exp_w.push_back(e);
            default: exp_s.push_back(e);
         endcase
      end
      case (which)
         0:       iv_u = 1'b1;
         1:       iv_w = 1'b1;
         default: iv_s = 1'b1;
      endcase
      @(posedge clk); #1;
      iv_u = 1'b0;
      iv_w = 1'b0;
      iv_s = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_u.size() + exp_w.size() + exp_s.size()) != 0 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_pending", 32'(exp_u.size() + exp_w.size() + exp_s.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int t;
      int seen;
      a = '0;
      b = '0;
      iv_u = 1'b0;
      iv_w = 1'b0;
      iv_s = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(ir_u), 32'd1);
      chk("rst_out_valid", 32'(ov_u), 32'd0);
      chk("rst_p_raw", 32'(praw_u), 32'd0);
      chk("rst_p_qm_n", 32'(pq_u), 32'd0);
      chk("rst_overflow", 32'(ovf_u), 32'd0);
      chk("rst_busy", 32'(busy_u), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: out_valid appears N+1 edges after the accept edge.
      issue(0, 8'h3C, 8'h12, {16'h0438, 8'h87, 1'b0}, 1'b1);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 1) chk("busy_in_calc", 32'(busy_u), 32'd1);
         if (i == 1) chk("in_ready_in_calc", 32'(ir_u), 32'd0);
         if (ov_u && lat == 0) lat = i;
      end
      chk("latency", 32'(lat), 32'd9);

      issue(0, 8'h39, 8'h3C, {16'h0D5C, 8'hFF, 1'b1}, 1'b1);
      issue(1, 8'h39, 8'h3C, {16'h0D5C, 8'hAC, 1'b1}, 1'b1);
      issue(2, 8'hF4, 8'h10, {16'hFF40, 8'hE8, 1'b0}, 1'b1);
      issue(0, 8'h08, 8'h08, {16'h0040, 8'h08, 1'b0}, 1'b1);
      issue(1, 8'hFF, 8'hFF, {16'hFE01, 8'hC0, 1'b1}, 1'b1);
      issue(2, 8'h80, 8'h80, {16'h4000, 8'h7F, 1'b1}, 1'b1);
      issue(0, 8'hFF, 8'hFF, {16'hFE01, 8'hFF, 1'b1}, 1'b1);
      issue(1, 8'h3C, 8'h12, {16'h0438, 8'h87, 1'b0}, 1'b1);
      issue(2, 8'h80, 8'h7F, {16'hC080, 8'h80, 1'b1}, 1'b1);
      issue(0, 8'h03, 8'h03, {16'h0009, 8'h01, 1'b0}, 1'b1);
      issue(2, 8'hF8, 8'hF8, {16'h0040, 8'h08, 1'b0}, 1'b1);
      issue(0, 8'h01, 8'h04, {16'h0004, 8'h01, 1'b0}, 1'b1);
      issue(2, 8'hFC, 8'h0C, {16'hFFD0, 8'hFA, 1'b0}, 1'b1);
      issue(0, 8'h01, 8'h03, {16'h0003, 8'h00, 1'b0}, 1'b1);
      issue(2, 8'hFF, 8'h04, {16'hFFFC, 8'h00, 1'b0}, 1'b1);
      issue(0, 8'h00, 8'h5A, {16'h0000, 8'h00, 1'b0}, 1'b1);
      drain();

      // Backpressure: result held, new operands ignored while DONE.
      out_ready = 1'b0;
      issue(0, 8'h3C, 8'h12, {16'h0438, 8'h87, 1'b0}, 1'b1);
      t = 0;
      while (!ov_u && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("bp_out_valid_rise", 32'(ov_u), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_out_valid", 32'(ov_u), 32'd1);
         chk("bp_hold_p_raw", 32'(praw_u), 32'h0438);
         chk("bp_hold_p_qm_n", 32'(pq_u), 32'h87);
         chk("bp_hold_overflow", 32'(ovf_u), 32'd0);
         chk("bp_hold_in_ready", 32'(ir_u), 32'd0);
         if (i == 1) begin
            a = 8'hFF;
            b = 8'hFF;
            iv_u = 1'b1;
         end
         if (i == 2) iv_u = 1'b0;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", 32'(ov_u), 32'd0);
      chk("bp_release_in_ready", 32'(ir_u), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_ignored_busy", 32'(busy_u), 32'd0);
      drain();

      // Reset during the third CALC cycle aborts the operation.
      issue(0, 8'h3C, 8'h12, '0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_busy", 32'(busy_u), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(ov_u), 32'd0);
      chk("mid_rst_busy", 32'(busy_u), 32'd0);
      chk("mid_rst_p_raw", 32'(praw_u), 32'd0);
      chk("mid_rst_p_qm_n", 32'(pq_u), 32'd0);
      chk("mid_rst_overflow", 32'(ovf_u), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(ir_u), 32'd1);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ov_u) seen++;
      end
      chk("post_rst_no_out_valid", 32'(seen), 32'd0);
      chk("post_rst_busy", 32'(busy_u), 32'd0);
      chk("final_pending", 32'(exp_u.size() + exp_w.size() + exp_s.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
